// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 25 MHz pixel clock domain.
// Produces registered sync, active-video, scaled pixel coordinates and
// line/frame pulses, plus delayed copies of active/hsync/vsync that line up
// with a downstream stage whose colour outputs are registered.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int H_SHIFT   = 1,
  parameter int V_SHIFT   = 0,
  parameter int PIPE_DLY  = 1
) (
  input  logic       clk25MHz,
  input  logic       rst,
  output logic [8:0] pos_x,
  output logic [8:0] pos_y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       active_d,
  output logic       hsync_d,
  output logic       vsync_d
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Counters are 10 bits, so the last count of a line/frame always fits.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode thresholds are one bit wider so a boundary of 1024 stays exact.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic SYNC_OFF = ~SYNC_POL;

  logic [9:0] hCnt_q, hCnt_d;
  logic [9:0] vCnt_q, vCnt_d;

  logic [8:0] posX_q, posX_d;
  logic [8:0] posY_q, posY_d;
  logic       active_q, activeNext;
  logic       hsync_q, hsyncNext;
  logic       vsync_q, vsyncNext;
  logic       lineStart_q, lineStartNext;
  logic       frameStart_q, frameStartNext;

  logic [10:0] hWide, vWide;
  logic        hVis, vVis, hSyncOn, vSyncOn;

  // Next counter values: h wraps every line, v advances only on the h wrap.
  always_comb begin
    hCnt_d = hCnt_q + 10'd1;
    vCnt_d = vCnt_q;
    if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
    end
  end

  // Decode the current counters into the values registered on the next edge.
  always_comb begin
    hWide          = {1'b0, hCnt_q};
    vWide          = {1'b0, vCnt_q};
    hVis           = hWide < H_VIS_END;
    vVis           = vWide < V_VIS_END;
    hSyncOn        = (hWide >= H_SYNC_BEG) && (hWide < H_SYNC_END);
    vSyncOn        = (vWide >= V_SYNC_BEG) && (vWide < V_SYNC_END);
    activeNext     = hVis && vVis;
    hsyncNext      = hSyncOn ? SYNC_POL : SYNC_OFF;
    vsyncNext      = vSyncOn ? SYNC_POL : SYNC_OFF;
    lineStartNext  = (hCnt_q == 10'd0) && vVis;
    frameStartNext = (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
    posX_d         = activeNext ? 9'(hCnt_q >> H_SHIFT) : 9'd0;
    posY_d         = activeNext ? 9'(vCnt_q >> V_SHIFT) : 9'd0;
  end

  // Counter and output registers; reset abandons the frame immediately.
  always_ff @(posedge clk25MHz) begin
    if (rst) begin
      hCnt_q       <= '0;
      vCnt_q       <= '0;
      posX_q       <= '0;
      posY_q       <= '0;
      active_q     <= 1'b0;
      hsync_q      <= SYNC_OFF;
      vsync_q      <= SYNC_OFF;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      posX_q       <= posX_d;
      posY_q       <= posY_d;
      active_q     <= activeNext;
      hsync_q      <= hsyncNext;
      vsync_q      <= vsyncNext;
      lineStart_q  <= lineStartNext;
      frameStart_q <= frameStartNext;
    end
  end

  assign pos_x       = posX_q;
  assign pos_y       = posY_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;

  generate
    if (PIPE_DLY == 0) begin : gNoDelay
      assign active_d = active_q;
      assign hsync_d  = hsync_q;
      assign vsync_d  = vsync_q;
    end else begin : gDelay
      logic [2:0] pipe_q [PIPE_DLY];

      // Shift the registered {active, hsync, vsync} down the delay line.
      always_ff @(posedge clk25MHz) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            pipe_q[i] <= {1'b0, SYNC_OFF, SYNC_OFF};
          end
        end else begin
          pipe_q[0] <= {active_q, hsync_q, vsync_q};
          for (int i = 1; i < PIPE_DLY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign {active_d, hsync_d, vsync_d} = pipe_q[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance and two small-raster
// instances share clock and reset. A count-based raster model predicts every
// output on every edge; random reset bursts are sprinkled through the run.
module tb_vga_timing_gen;

  typedef struct {
    int hVis, hFp, hSyn, hBp;
    int vVis, vFp, vSyn, vBp;
    bit pol;
    int hSh, vSh, dly;
  } cfg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  cfg_t        cfg [3];
  longint      cnt [3];
  logic [22:0] hist [3][8];
  logic [25:0] obs [3];

  logic [8:0] pxA, pyA, pxB, pyB, pxC, pyC;
  logic actA, hsA, vsA, lsA, fsA, adA, hdA, vdA;
  logic actB, hsB, vsB, lsB, fsB, adB, hdB, vdB;
  logic actC, hsC, vsC, lsC, fsC, adC, hdC, vdC;

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  vga_timing_gen dutA (
    .clk25MHz(clk), .rst(rst), .pos_x(pxA), .pos_y(pyA), .active(actA),
    .hsync(hsA), .vsync(vsA), .line_start(lsA), .frame_start(fsA),
    .active_d(adA), .hsync_d(hdA), .vsync_d(vdA)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .PIPE_DLY(3)
  ) dutB (
    .clk25MHz(clk), .rst(rst), .pos_x(pxB), .pos_y(pyB), .active(actB),
    .hsync(hsB), .vsync(vsB), .line_start(lsB), .frame_start(fsB),
    .active_d(adB), .hsync_d(hdB), .vsync_d(vdB)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .H_SHIFT(0), .V_SHIFT(1), .PIPE_DLY(0)
  ) dutC (
    .clk25MHz(clk), .rst(rst), .pos_x(pxC), .pos_y(pyC), .active(actC),
    .hsync(hsC), .vsync(vsC), .line_start(lsC), .frame_start(fsC),
    .active_d(adC), .hsync_d(hdC), .vsync_d(vdC)
  );

  assign obs[0] = {pxA, pyA, actA, hsA, vsA, lsA, fsA, adA, hdA, vdA};
  assign obs[1] = {pxB, pyB, actB, hsB, vsB, lsB, fsB, adB, hdB, vdB};
  assign obs[2] = {pxC, pyC, actC, hsC, vsC, lsC, fsC, adC, hdC, vdC};

  // Expected {pos_x, pos_y, active, hsync, vsync, line_start, frame_start}
  // for the c-th pixel since the counters were cleared.
  function automatic logic [22:0] decodeCount(cfg_t k, longint c);
    longint ht, vt, h, v, hsBeg, vsBeg;
    logic vis, hs, vs;
    logic [8:0] px, py;
    ht    = k.hVis + k.hFp + k.hSyn + k.hBp;
    vt    = k.vVis + k.vFp + k.vSyn + k.vBp;
    h     = c % ht;
    v     = (c / ht) % vt;
    hsBeg = k.hVis + k.hFp;
    vsBeg = k.vVis + k.vFp;
    vis   = (h < k.hVis) && (v < k.vVis);
    px    = vis ? 9'(h / (longint'(1) << k.hSh)) : 9'd0;
    py    = vis ? 9'(v / (longint'(1) << k.vSh)) : 9'd0;
    hs    = (h >= hsBeg && h < hsBeg + k.hSyn) ? k.pol : ~k.pol;
    vs    = (v >= vsBeg && v < vsBeg + k.vSyn) ? k.pol : ~k.pol;
    return {px, py, vis, hs, vs, (h == 0 && v < k.vVis), (h == 0 && v == 0)};
  endfunction

  function automatic logic [22:0] resetVal(cfg_t k);
    return {9'd0, 9'd0, 1'b0, ~k.pol, ~k.pol, 1'b0, 1'b0};
  endfunction

  // Compare every instance against the model, #1 after the edge.
  task automatic checkOutput();
    logic [25:0] expv;
    logic [22:0] dl;
    for (int i = 0; i < 3; i++) begin
      dl   = hist[i][cfg[i].dly];
      expv = {hist[i][0], dl[4], dl[3], dl[2]};
      checks++;
      assert (obs[i] === expv) else begin
        errors++;
        $error("[TB] FAIL raster_dut%0d (count %0d): observed %h expected %h",
               i, cnt[i], obs[i], expv);
      end
    end
  endtask

  // Drive reset for one edge, advance the model, then check.
  task automatic applyStimulus(input bit r);
    rst = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        cnt[i] = 0;
        for (int j = 0; j < 8; j++) hist[i][j] = resetVal(cfg[i]);
      end else begin
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = decodeCount(cfg[i], cnt[i]);
        cnt[i]++;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int actCnt, hsLowCnt, fsCntB, lsCntB, vsHighCntB, nRun, nRst;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1, 0, 1};
    cfg[1] = '{16, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1, 0, 3};
    cfg[2] = '{16, 2, 3, 3, 4, 1, 1, 1, 1'b0, 0, 1, 0};

    // Reset hold
    for (int n = 0; n < 5; n++) applyStimulus(1'b1);
    checkValue("reset_hsync", int'(hsA), 1);
    checkValue("reset_vsync", int'(vsA), 1);
    checkValue("reset_hsync_d", int'(hdA), 1);
    checkValue("reset_active", int'(actA), 0);

    // First edge after release shows pixel (0,0)
    applyStimulus(1'b0);
    checkValue("first_frame_start", int'(fsA), 1);
    checkValue("first_active", int'(actA), 1);
    checkValue("first_pos", int'({pxA, pyA}), 0);

    // One full default line, and one full small frame on dutB
    actCnt = int'(actA);
    hsLowCnt = int'(!hsA);
    fsCntB = int'(fsB);
    lsCntB = int'(lsB);
    vsHighCntB = int'(vsB);
    for (int n = 2; n <= 800; n++) begin
      applyStimulus(1'b0);
      actCnt += int'(actA);
      hsLowCnt += int'(!hsA);
      if (n <= 168) begin
        fsCntB += int'(fsB);
        lsCntB += int'(lsB);
        vsHighCntB += int'(vsB);
      end
    end
    checkValue("line_active_cycles", actCnt, 640);
    checkValue("line_hsync_low_cycles", hsLowCnt, 96);
    checkValue("small_frame_starts", fsCntB, 1);
    checkValue("small_line_starts", lsCntB, 4);
    checkValue("small_vsync_cycles", vsHighCntB, 24);

    applyStimulus(1'b0);
    checkValue("line1_start", int'(lsA), 1);
    checkValue("line1_pos_y", int'(pyA), 1);

    // Mid-line reset while hsync is asserted
    while (cnt[0] < 3 * 800 + 700) applyStimulus(1'b0);
    checkValue("pre_reset_hsync", int'(hsA), 0);
    applyStimulus(1'b1);
    checkValue("midreset_hsync", int'(hsA), 1);
    applyStimulus(1'b0);
    checkValue("midreset_frame_start", int'(fsA), 1);
    checkValue("midreset_pos", int'({pxA, pyA}), 0);

    // Random run lengths separated by random reset bursts
    for (int it = 0; it < 30; it++) begin
      nRun = int'($urandom_range(50, 1500));
      for (int n = 0; n < nRun; n++) applyStimulus(1'b0);
      nRst = int'($urandom_range(1, 3));
      for (int n = 0; n < nRst; n++) applyStimulus(1'b1);
    end
    for (int n = 0; n < 200; n++) applyStimulus(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
